// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - run-controlled cycle/event counters with saturation, limit stop and snapshot shadows
module perf_monitor #(
  parameter int NUM_EVT = 2,
  parameter int CNT_W   = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [NUM_EVT-1:0]               evt_i,
  input  logic [CNT_W-1:0]                 limit_i,
  input  logic                             snap_i,
  input  logic [$clog2(NUM_EVT+1)-1:0]     rd_sel_i,
  output logic [CNT_W-1:0]                 rd_data_o,
  output logic [CNT_W-1:0]                 cycle_o,
  output logic                             running_o,
  output logic                             done_o,
  output logic [NUM_EVT:0]                 ovf_o
);

  localparam int              SEL_W   = $clog2(NUM_EVT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Slot 0 is the cycle counter, slot k is event channel k-1; shadows and
  // overflow flags use the same layout so snapshots are a single copy.
  logic [NUM_EVT:0][CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic [NUM_EVT:0][CNT_W-1:0] shd_q, shd_d;
  logic [NUM_EVT:0]            ovf_q, ovf_d;
  logic [NUM_EVT:0]            inc_req, sat_hit;
  logic                        count_en;
  logic                        limit_hit;

  // Saturating increment candidates for every counter slot.
  always_comb begin : incr_calc
    cnt_nx  = cnt_q;
    sat_hit = '0;
    inc_req = {evt_i, 1'b1};
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (inc_req[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          sat_hit[k] = 1'b1;
        end else begin
          cnt_nx[k] = cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  // A counting edge is any edge with start high outside DONE; the edges that
  // enter RUN from IDLE or PAUSE count as RUN cycles too.
  always_comb begin : count_ctrl
    count_en  = start_i && (state_q != DONE);
    limit_hit = count_en && (limit_i != '0) && (cnt_nx[0] == limit_i);
  end

  // Next-state logic; clear overrides every other input.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE, PAUSE: begin
        if (start_i) state_d = limit_hit ? DONE : RUN;
      end
      RUN: begin
        if (!start_i)       state_d = PAUSE;
        else if (limit_hit) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Counter, shadow and overflow updates; the limit stop captures final
  // post-increment values and takes precedence over a same-edge snapshot.
  always_comb begin : data_next
    cnt_d = cnt_q;
    shd_d = shd_q;
    ovf_d = ovf_q;
    if (count_en) begin
      cnt_d = cnt_nx;
      ovf_d = ovf_q | sat_hit;
    end
    if (snap_i)    shd_d = cnt_q;
    if (limit_hit) shd_d = cnt_nx;
    if (clear_i) begin
      cnt_d = '0;
      shd_d = '0;
      ovf_d = '0;
    end
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin : regs
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shd_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shd_q   <= shd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Shadow read mux; selects beyond the last channel read as zero.
  always_comb begin : rd_mux
    rd_data_o = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_data_o = shd_q[k];
    end
  end

  assign cycle_o   = cnt_q[0];
  assign running_o = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - directed and randomized checks of perf_monitor against a behavioural model
module tb_perf_monitor;

  logic       clk = 1'b0;
  logic       rst_n, start, clr, snap;
  logic [1:0] evt;
  logic [7:0] limit;
  logic [1:0] rd_sel;
  logic [7:0] rd_data, cyc;
  logic       running, done;
  logic [2:0] ovf;

  logic [3:0] limit4;
  logic [3:0] rd_data4, cyc4;
  logic       running4, done4;
  logic [2:0] ovf4;

  int checks = 0;
  int errors = 0;

  // behavioural model of the 8-bit instance
  int     m_cnt[3];
  int     m_shd[3];
  bit [2:0] m_ovf;
  bit     m_done, m_run;

  always #5 clk = ~clk;

  perf_monitor #(.NUM_EVT(2), .CNT_W(8)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clr), .evt_i(evt),
    .limit_i(limit), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .cycle_o(cyc), .running_o(running), .done_o(done), .ovf_o(ovf)
  );

  perf_monitor #(.NUM_EVT(2), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clr), .evt_i(evt),
    .limit_i(limit4), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_data4),
    .cycle_o(cyc4), .running_o(running4), .done_o(done4), .ovf_o(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1'b1; start = 1'b0; snap = 1'b0; evt = 2'b00;
    tick();
    clr = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_shd[k] = 0;
    end
    m_ovf = '0; m_done = 0; m_run = 0;
  endtask

  task automatic model_step();
    int  old[3];
    bit  counting;
    if (clr) begin
      model_reset();
      return;
    end
    old = m_cnt;
    counting = start && !m_done;
    if (counting) begin
      for (int k = 0; k < 3; k++) begin
        if (k == 0 || evt[k-1]) begin
          if (m_cnt[k] == 255) m_ovf[k] = 1'b1;
          else m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    if (snap) m_shd = old;
    if (counting && limit != 0 && m_cnt[0] == int'(limit)) begin
      m_done = 1'b1;
      m_shd  = m_cnt;
    end
    m_run = counting && !m_done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cyc !== 8'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cyc); end
    checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags: got run=%b done=%b expected 0/0", running, done); end
    checks++; if (ovf !== 3'b000 || ovf4 !== 3'b000) begin errors++; $display("FAIL reset_ovf: got %b/%b expected 000", ovf, ovf4); end
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s); #1;
      checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd%0d: got %0d expected 0", s, rd_data); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_limit_run();
    int exp_rd[3];
    exp_rd = '{19, 3, 2};
    do_clear();
    limit = 8'd19; start = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      evt[0] = (i <= 3);
      evt[1] = (i <= 2);
      tick();
      if (i == 18) begin
        checks++; if (done !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL limit_early: got run=%b done=%b expected 1/0", running, done); end
      end
    end
    evt = 2'b00;
    checks++; if (done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL limit_done: got run=%b done=%b expected 0/1", running, done); end
    checks++; if (cyc !== 8'd19) begin errors++; $display("FAIL limit_cycle: got %0d expected 19", cyc); end
    for (int s = 0; s < 3; s++) begin
      rd_sel = 2'(s); #1;
      checks++; if (rd_data !== 8'(exp_rd[s])) begin errors++; $display("FAIL limit_rd%0d: got %0d expected %0d", s, rd_data, exp_rd[s]); end
    end
    evt = 2'b11;
    tick();
    tick();
    checks++; if (cyc !== 8'd19 || done !== 1'b1) begin errors++; $display("FAIL done_hold: got cyc=%0d done=%b expected 19/1", cyc, done); end
  endtask

  task automatic test_pause();
    do_clear();
    limit = 8'd0; start = 1'b1;
    repeat (5) tick();
    checks++; if (cyc !== 8'd5 || running !== 1'b1) begin errors++; $display("FAIL pause_pre: got cyc=%0d run=%b expected 5/1", cyc, running); end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (cyc !== 8'd5 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL pause_hold%0d: got cyc=%0d run=%b done=%b expected 5/0/0", i, cyc, running, done); end
    end
    start = 1'b1;
    repeat (3) tick();
    checks++; if (cyc !== 8'd8 || done !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL pause_final: got cyc=%0d done=%b expected 8/0", cyc, done); end
  endtask

  task automatic test_saturation();
    do_clear();
    limit4 = 4'd0; start = 1'b1; evt = 2'b01;
    repeat (15) tick();
    checks++; if (ovf4 !== 3'b000 || cyc4 !== 4'd15) begin errors++; $display("FAIL sat_pre: got ovf=%b cyc=%0d expected 000/15", ovf4, cyc4); end
    tick();
    checks++; if (ovf4 !== 3'b011) begin errors++; $display("FAIL sat_ovf16: got %b expected 011", ovf4); end
    tick();
    checks++; if (cyc4 !== 4'd15 || ovf4 !== 3'b011) begin errors++; $display("FAIL sat_nowrap: got cyc=%0d ovf=%b expected 15/011", cyc4, ovf4); end
    start = 1'b0; snap = 1'b1; evt = 2'b00;
    tick();
    snap = 1'b0;
    rd_sel = 2'd1; #1;
    checks++; if (rd_data4 !== 4'd15) begin errors++; $display("FAIL sat_ch0: got %0d expected 15", rd_data4); end
    rd_sel = 2'd2; #1;
    checks++; if (rd_data4 !== 4'd0) begin errors++; $display("FAIL sat_ch1: got %0d expected 0", rd_data4); end
  endtask

  task automatic test_clear_priority();
    start = 1'b1;
    tick();
    clr = 1'b1; snap = 1'b1; start = 1'b1; evt = 2'b11;
    tick();
    clr = 1'b0; snap = 1'b0; start = 1'b0; evt = 2'b00;
    checks++; if (running !== 1'b0 || done !== 1'b0 || running4 !== 1'b0) begin errors++; $display("FAIL clr_state: got run=%b done=%b expected 0/0", running, done); end
    checks++; if (cyc !== 8'd0 || cyc4 !== 4'd0) begin errors++; $display("FAIL clr_cycle: got %0d/%0d expected 0", cyc, cyc4); end
    checks++; if (ovf !== 3'b000 || ovf4 !== 3'b000) begin errors++; $display("FAIL clr_ovf: got %b/%b expected 000", ovf, ovf4); end
    for (int s = 0; s < 3; s++) begin
      rd_sel = 2'(s); #1;
      checks++; if (rd_data !== 8'd0 || rd_data4 !== 4'd0) begin errors++; $display("FAIL clr_rd%0d: got %0d/%0d expected 0", s, rd_data, rd_data4); end
    end
  endtask

  task automatic test_snapshot();
    int ev_cnt = 0;
    int snap_ev;
    do_clear();
    limit = 8'd0; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      evt[1] = (i % 2 == 0);
      ev_cnt += int'(evt[1]);
      tick();
    end
    checks++; if (cyc !== 8'd7) begin errors++; $display("FAIL snap_pre: got %0d expected 7", cyc); end
    snap_ev = ev_cnt;
    snap = 1'b1; evt[1] = 1'b0;
    tick();
    snap = 1'b0;
    rd_sel = 2'd0; #1;
    checks++; if (rd_data !== 8'd7) begin errors++; $display("FAIL snap_cyc: got %0d expected 7", rd_data); end
    for (int i = 8; i < 13; i++) begin
      evt[1] = (i % 2 == 0);
      tick();
    end
    rd_sel = 2'd0; #1;
    checks++; if (rd_data !== 8'd7) begin errors++; $display("FAIL snap_frozen: got %0d expected 7", rd_data); end
    rd_sel = 2'd2; #1;
    checks++; if (rd_data !== 8'(snap_ev)) begin errors++; $display("FAIL snap_ch1: got %0d expected %0d", rd_data, snap_ev); end
    checks++; if (cyc !== 8'd13) begin errors++; $display("FAIL snap_live: got %0d expected 13", cyc); end
    rd_sel = 2'd3; #1;
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL rd_oob: got %0d expected 0", rd_data); end
  endtask

  task automatic test_limit_lower();
    do_clear();
    limit = 8'd0; start = 1'b1; evt = 2'b00;
    repeat (10) tick();
    limit = 8'd5;
    repeat (5) tick();
    checks++; if (done !== 1'b0 || cyc !== 8'd15) begin errors++; $display("FAIL lower_nostop: got done=%b cyc=%0d expected 0/15", done, cyc); end
    limit = 8'd18;
    repeat (2) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL raise_early: got %b expected 0", done); end
    tick();
    checks++; if (done !== 1'b1 || cyc !== 8'd18) begin errors++; $display("FAIL raise_stop: got done=%b cyc=%0d expected 1/18", done, cyc); end
  endtask

  task automatic test_async_reset();
    do_clear();
    limit = 8'd0; start = 1'b1; evt = 2'b11;
    repeat (4) tick();
    checks++; if (cyc !== 8'd4 || running !== 1'b1) begin errors++; $display("FAIL ar_pre: got cyc=%0d run=%b expected 4/1", cyc, running); end
    snap = 1'b1; tick(); snap = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    rd_sel = 2'd1;
    #0.5;
    checks++; if (cyc !== 8'd0 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ar_now: got cyc=%0d run=%b done=%b expected 0/0/0", cyc, running, done); end
    checks++; if (rd_data !== 8'd0 || ovf !== 3'b000 || cyc4 !== 4'd0) begin errors++; $display("FAIL ar_data: got rd=%0d ovf=%b cyc4=%0d expected 0", rd_data, ovf, cyc4); end
    @(negedge clk);
    checks++; if (cyc !== 8'd0) begin errors++; $display("FAIL ar_held: got %0d expected 0", cyc); end
    rst_n = 1'b1;
    tick();
    checks++; if (cyc !== 8'd1 || running !== 1'b1) begin errors++; $display("FAIL ar_restart: got cyc=%0d run=%b expected 1/1", cyc, running); end
  endtask

  task automatic test_random();
    logic [7:0] exp_rd;
    do_clear();
    model_reset();
    limit = 8'd0;
    for (int n = 0; n < 3000; n++) begin
      start  = ($urandom_range(0, 9) != 0);
      evt    = 2'($urandom);
      snap   = ($urandom_range(0, 7) == 0);
      clr    = ($urandom_range(0, 299) == 0);
      rd_sel = 2'($urandom);
      if ($urandom_range(0, 19) == 0)
        limit = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
      @(posedge clk);
      model_step();
      @(negedge clk);
      exp_rd = (rd_sel <= 2'd2) ? 8'(m_shd[rd_sel]) : 8'd0;
      checks++; if (cyc !== 8'(m_cnt[0])) begin errors++; $display("FAIL rnd_cycle@%0d: got %0d expected %0d", n, cyc, m_cnt[0]); end
      checks++; if (running !== m_run || done !== m_done) begin errors++; $display("FAIL rnd_state@%0d: got run=%b done=%b expected %b/%b", n, running, done, m_run, m_done); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %b expected %b", n, ovf, m_ovf); end
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rnd_rd@%0d sel=%0d: got %0d expected %0d", n, rd_sel, rd_data, exp_rd); end
    end
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; snap = 1'b0;
    evt = 2'b00; limit = 8'd0; limit4 = 4'd0; rd_sel = 2'd0;
    test_reset();
    test_limit_run();
    test_pause();
    test_saturation();
    test_clear_priority();
    test_snapshot();
    test_limit_lower();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 The block SHALL have parameter NUM_EVT, default 2, giving the number of event channels (ch0 = stall, ch1 = flush by convention).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of every counter.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock, all state rising-edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start_i, input, 1 bit: run enable, level-sensitive.
REQ-006 The block SHALL have port clear_i, input, 1 bit: synchronous clear of counters and state.
REQ-007 The block SHALL have port evt_i, input, NUM_EVT bits: per-channel event strobes, one count per high cycle.
REQ-008 The block SHALL have port limit_i, input, CNT_W bits: cycle limit; 0 means unlimited.
REQ-009 The block SHALL have port snap_i, input, 1 bit: snapshot request.
REQ-010 The block SHALL have port rd_sel_i, input, clog2(NUM_EVT+1) bits: shadow select (0 = cycle count, k = event channel k-1).
REQ-011 The block SHALL have port rd_data_o, output, CNT_W bits: selected shadow value.
REQ-012 The block SHALL have port cycle_o, output, CNT_W bits: live cycle counter.
REQ-013 The block SHALL have port running_o, output, 1 bit: high in RUN.
REQ-014 The block SHALL have port done_o, output, 1 bit: high in DONE.
REQ-015 The block SHALL have port ovf_o, output, NUM_EVT+1 bits: sticky saturation flags (bit 0 = cycle counter, bit k = channel k-1).

Function
REQ-016 The block SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-017 Transitions SHALL be: IDLE->RUN on start_i=1; RUN->PAUSE on start_i=0; PAUSE->RUN on start_i=1; RUN->DONE when the cycle counter's next value equals a nonzero limit_i.
REQ-018 clear_i=1 SHALL take any state to IDLE, zero all live counters, shadows and ovf_o on the next edge, and override all other inputs that cycle.
REQ-019 DONE SHALL be left only by clear_i or reset; start_i SHALL be ignored in DONE.
REQ-020 In RUN, the cycle counter SHALL increment by 1 every clock, including the RUN->DONE cycle.
REQ-021 In RUN, event counter k SHALL increment by 1 on each edge where evt_i[k]=1, including the RUN->DONE cycle.
REQ-022 Events and cycles SHALL NOT be counted in IDLE, PAUSE or DONE; counters SHALL hold their values there.
REQ-023 The IDLE->RUN edge SHALL count as the first RUN cycle: cycle_o=1 after that edge, and evt_i sampled on that edge SHALL count.
REQ-024 Each counter SHALL saturate at 2^CNT_W-1 rather than wrap, and SHALL set its ovf_o bit on the attempted increment beyond that value.
REQ-025 ovf_o bits SHALL remain set until clear_i or reset.
REQ-026 When snap_i=1 (and clear_i=0), all shadows SHALL load the live counter register values present before that edge, atomically across channels, visible on rd_data_o one cycle after the request.
REQ-027 On the RUN->DONE edge, shadows SHALL automatically load the post-increment final values.
REQ-028 rd_data_o SHALL be a combinational mux of the shadows selected by rd_sel_i; out-of-range selects SHALL return 0.
REQ-029 limit_i SHALL be sampled every RUN cycle; a limit lowered below the current count SHALL never terminate the run (equality only).

Reset
REQ-030 While rst_i=0, state SHALL be IDLE and cycle_o, all event counters, shadows, rd_data_o, ovf_o, running_o and done_o SHALL be 0, asynchronously.
REQ-031 Reset deasserted mid-RUN SHALL resume in IDLE with all counters 0; there SHALL be no resumption of the prior run.
REQ-032 Reset release SHALL be sampled on clk_i, and the first state change SHALL be allowed on the edge after release.

Verification
REQ-033 Scenario: limit_i=19, start_i held high, evt_i[0] high for 3 cycles, evt_i[1] high for 2 cycles -> done_o rises after the 19th RUN edge, cycle_o=19, rd_sel_i=0/1/2 reads 19/3/2, running_o=0.
REQ-034 Scenario: start_i high for 5 cycles, low for 4, high for 3 (limit_i=0) -> PAUSE for 4 cycles with cycle_o held at 5, final cycle_o=8, done_o stays 0.
REQ-035 Scenario: CNT_W=4, evt_i[0] high for 17 RUN cycles -> channel 0 reads 15, ovf_o[1]=1, ovf_o[0]=1 after the 16th cycle, no wrap.
REQ-036 Scenario: snap_i pulsed at cycle_o=7 while evt_i[1] keeps toggling -> rd_sel_i=0 reads 7 next cycle, shadows stay frozen while live counters advance.
REQ-037 Scenario: clear_i asserted in the same cycle as snap_i and start_i during RUN -> next cycle state is IDLE, all counters, shadows and ovf_o are 0, running_o=0.
REQ-038 Scenario: rst_i driven low mid-RUN, asynchronous to clk_i -> all outputs go to 0 immediately without a clock edge; after release plus start_i, cycle_o restarts at 1.
